sub_1506_seq: RTL and testbench
===============================

Name: sub_1506_seq

Overview:
- Multi-cycle 1506-bit subtractor. Computes d = a - b mod 2^1506 one 128-bit limb per cycle, LSB limb first, with a registered borrow.
- Produces the 4-bit correction index M consumed by the downstream correction-constant lookup.
- Sits in the Fp arithmetic datapath of the 1506x1506 core, ahead of the correction adder.
- Replaces a single-cycle 1506-bit carry chain for timing closure.

Parameters:
- WIDTH, 1506, operand and result width in bits.
- LIMB, 128, limb width processed per cycle.
- NLIMB, 12, limb count, ceil(WIDTH/LIMB). Derived; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  1506  minuend
- b  input  1506  subtrahend
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  1506  a - b mod 2^1506
- borrow  output  1  1 when a < b
- m_idx  output  4  correction index, {borrow, diff[1505:1503]}

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, m_idx=0, limb counter=0, borrow register=0.
- Reset overrides everything, including a job in progress. No partial result is ever presented after reset.
- FSM states:
  - IDLE: in_ready=1. When in_valid&in_ready, capture a and b into internal registers, clear the borrow register, set the counter to 0, go to RUN.
  - RUN: in_ready=0. Each cycle, for limb k: {br', d_k} = a_k - b_k - br. Write d_k into diff[k*LIMB +: LIMB] and increment k.
    - The last limb (k=11) is 98 bits wide (bits 1505:1408). Its borrow-out is the final borrow.
    - After limb 11 is processed, go to DONE.
  - DONE: out_valid=1. diff, borrow and m_idx stay stable until out_valid&out_ready, then go to IDLE.
- Latency: accept edge to out_valid high is NLIMB+1 = 13 cycles. Throughput is one result per 14 cycles with out_ready held high.
- No operand bypass. in_ready is 0 in RUN and DONE, so back-to-back accepts are impossible.
- m_idx is combinational from the registered diff and borrow, valid only while out_valid=1.
- diff bits not yet written keep their previous values during RUN. Consumers read only under out_valid.
- Edge cases:
  - a == b: diff=0, borrow=0, m_idx=0.
  - a=0, b=1: diff is all ones, borrow=1, m_idx=4'hF.
- in_valid asserted during RUN or DONE is ignored, and the operands are not captured.
- out_ready asserted outside DONE has no effect.

Optional Feature:
- Macro: SUB_1506_SEQ_ABORT_EN.
- Defined: adds an input port abort (1 bit).
  - abort=1 in RUN or DONE forces IDLE on the next edge with out_valid=0.
  - abort has priority over a same-cycle out_ready, which means the result is dropped.
  - abort in IDLE is a no-op. abort and in_valid in the same IDLE cycle: the accept wins.
- Undefined: port absent; behaviour as above.

Decomposition:
- Shared package sub_1506_pkg holds:
  - constants WIDTH_1506=1506, LIMB_W=128, NLIMB_1506=12, LAST_LIMB_W=98;
  - the state enum {ST_IDLE, ST_RUN, ST_DONE};
  - the M index type (4-bit).
- One natural sub-module, sub_limb_128: combinational LIMB-bit subtract with borrow-in/borrow-out. Instantiated once and time-shared across limbs; the last limb is zero-extended to 128 bits.
- The FSM, counter and registers stay in the top.

Test Plan:
- a=5, b=3 accepted at cycle 0 -> out_valid at cycle 13; diff=2, borrow=0, m_idx=0.
- a=0, b=1 -> diff=2^1506-1 (all ones), borrow=1, m_idx=4'hF.
- a=2^128, b=1 -> borrow crosses the limb 0/1 boundary; diff=2^128-1, borrow=0, m_idx=0.
- a=2^1505, b=0 -> m_idx=4'h4.
- a=2^1505+2^1503, b=0 -> m_idx=4'h5.
- Backpressure: out_ready low for 5 cycles in DONE -> outputs held stable, in_ready=0, in_valid pulses ignored. Release -> IDLE next cycle with in_ready=1.
- rst_n low at RUN cycle 6 -> next cycle IDLE, out_valid=0, diff=0.
  - The next job a=7, b=9 completes normally: diff=2^1506-2, borrow=1.
  - With SUB_1506_SEQ_ABORT_EN: abort at RUN cycle 4 -> IDLE, no out_valid pulse.

Source files
------------

// File: rtl/sub_1506_pkg.sv
// Shared constants and types for the limb-serial 1506-bit subtractor.
package sub_1506_pkg;
  localparam int WIDTH_1506  = 1506;
  localparam int LIMB_W      = 128;
  localparam int NLIMB_1506  = 12;
  localparam int LAST_LIMB_W = 98;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  typedef logic [3:0] m_idx_t;
endpackage

// File: rtl/sub_limb_128.sv
// One limb of the serial subtractor: {bo, d} = a - b - bi.
module sub_limb_128 #(
  parameter int W = 128
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bi,
  output logic [W-1:0] d,
  output logic         bo
);
  // One extra bit catches the wrap; it is set exactly when the result went negative.
  assign {bo, d} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
endmodule

// File: rtl/sub_1506_seq.sv
// Multi-cycle a - b mod 2^1506, one limb per cycle, LSB limb first.
// Optional SUB_1506_SEQ_ABORT_EN adds an abort input that drops a job in flight.
module sub_1506_seq
  import sub_1506_pkg::*;
#(
  parameter int WIDTH = WIDTH_1506,
  parameter int LIMB  = LIMB_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
`ifdef SUB_1506_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output m_idx_t           m_idx
);
  localparam int NLIMB  = (WIDTH + LIMB - 1) / LIMB;
  localparam int LAST_W = WIDTH - (NLIMB - 1) * LIMB;
  localparam int CW     = $clog2(NLIMB);

  state_e                       state, state_nx;
  logic [NLIMB-1:0][LIMB-1:0]   a_r, b_r;
  logic [NLIMB-2:0][LIMB-1:0]   diff_lo;
  logic [LAST_W-1:0]            diff_hi;
  logic [CW-1:0]                cnt;
  logic                         br;
  logic [LIMB-1:0]              d_k;
  logic                         bo;
  logic                         accept, last, kill;

`ifdef SUB_1506_SEQ_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(NLIMB - 1));

  // Operands are zero-padded, so the top limb's borrow-out equals the narrow limb's.
  sub_limb_128 #(.W(LIMB)) u_limb (
    .a  (a_r[cnt]),
    .b  (b_r[cnt]),
    .bi (br),
    .d  (d_k),
    .bo (bo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (kill)      state_nx = ST_IDLE;
        else if (last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (kill || out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      diff_lo <= '0;
      diff_hi <= '0;
      cnt     <= '0;
      br      <= 1'b0;
    end else if (accept) begin
      a_r <= (NLIMB * LIMB)'(a);
      b_r <= (NLIMB * LIMB)'(b);
      cnt <= '0;
      br  <= 1'b0;
    end else if (state == ST_RUN && !kill) begin
      br  <= bo;
      cnt <= cnt + 1'b1;
      if (last) diff_hi      <= d_k[LAST_W-1:0];
      else      diff_lo[cnt] <= d_k;
    end
  end

  assign diff   = {diff_hi, diff_lo};
  assign borrow = br;
  assign m_idx  = {br, diff_hi[LAST_W-1 -: 3]};
endmodule

// File: tb/tb_sub_1506_seq.sv
// Scoreboard bench for sub_1506_seq; abort scenario built with SUB_1506_SEQ_ABORT_EN.
module tb_sub_1506_seq;
  localparam int W = 1506;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic [3:0]   m;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, borrow;
  logic [W-1:0] diff;
  logic [3:0]   m_idx;
`ifdef SUB_1506_SEQ_ABORT_EN
  logic         abort = 1'b0;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  sub_1506_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
`ifdef SUB_1506_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .m_idx     (m_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < 48; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.d  = x - y;
    e.br = (x < y);
    e.m  = {e.br, e.d[W-1:W-3]};
    sb.push_back(e);
  endtask

  // Drives one operand pair from IDLE; returns 1 ns after the accept edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    in_valid = 1'b1;
    a = x;
    b = y;
    push_exp(x, y);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge (inclusive) to out_valid; 40 means timeout.
  task automatic wait_out(output int lat);
    lat = 1;
    while (lat < 40) begin
      @(negedge clk);
      if (out_valid) return;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (diff !== '0) begin errors++; $display("FAIL reset_diff got %h exp 0", diff); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b exp 0", borrow); end
    checks++; if (m_idx !== 4'h0) begin errors++; $display("FAIL reset_m_idx got %h exp 0", m_idx); end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [W-1:0] va[7], vb[7];
    logic [3:0]   vm[5];
    exp_t e;
    int lat;
    va[0] = W'(5);  vb[0] = W'(3);  vm[0] = 4'h0;
    va[1] = '0;     vb[1] = W'(1);  vm[1] = 4'hF;
    va[2] = '0; va[2][128] = 1'b1; vb[2] = W'(1); vm[2] = 4'h0;
    va[3] = '0; va[3][1505] = 1'b1; vb[3] = '0; vm[3] = 4'h4;
    va[4] = va[3]; va[4][1503] = 1'b1; vb[4] = '0; vm[4] = 4'h5;
    va[5] = rnd(); vb[5] = va[5];
    va[6] = rnd(); vb[6] = rnd();
    for (int i = 0; i < 7; i++) begin
      send(va[i], vb[i]);
      wait_out(lat);
      checks++; if (lat !== 13) begin errors++; $display("FAIL vec%0d_latency got %0d exp 13", i, lat); end
      e = sb.pop_front();
      checks++; if (diff !== e.d) begin errors++; $display("FAIL vec%0d_diff got %h exp %h", i, diff, e.d); end
      checks++; if (borrow !== e.br) begin errors++; $display("FAIL vec%0d_borrow got %b exp %b", i, borrow, e.br); end
      checks++; if (m_idx !== e.m) begin errors++; $display("FAIL vec%0d_m_idx got %h exp %h", i, m_idx, e.m); end
      if (i < 5) begin
        checks++; if (m_idx !== vm[i]) begin errors++; $display("FAIL vec%0d_m_const got %h exp %h", i, m_idx, vm[i]); end
      end
      release_out();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL vec%0d_to_idle got rdy=%b vld=%b exp rdy=1 vld=0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int lat;
    send(rnd(), rnd());
    wait_out(lat);
    checks++; if (lat !== 13) begin errors++; $display("FAIL bp_latency got %0d exp 13", lat); end
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 in_valid = 1'b1; a = rnd(); b = rnd();
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got vld=%b rdy=%b exp vld=1 rdy=0", i, out_valid, in_ready);
      end
      checks++; if (diff !== e.d || borrow !== e.br || m_idx !== e.m) begin
        errors++; $display("FAIL bp_stable%0d got %h/%b/%h exp %h/%b/%h", i, diff, borrow, m_idx, e.d, e.br, e.m);
      end
    end
    in_valid = 1'b0;
    release_out();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int lat;
    int seen = 0;
    send('0, W'(1));
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
    checks++; if (diff !== '0 || borrow !== 1'b0) begin
      errors++; $display("FAIL rst_mid_clear got %h/%b exp 0/0", diff, borrow);
    end
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_output got %0d pulses exp 0", seen); end
    send(W'(7), W'(9));
    wait_out(lat);
    checks++; if (lat !== 13) begin errors++; $display("FAIL rst_next_latency got %0d exp 13", lat); end
    e = sb.pop_front();
    checks++; if (diff !== e.d || diff !== ('1 << 1)) begin errors++; $display("FAIL rst_next_diff got %h exp %h", diff, e.d); end
    checks++; if (borrow !== 1'b1) begin errors++; $display("FAIL rst_next_borrow got %b exp 1", borrow); end
    release_out();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int acc[$];
    int lat;
    logic [W-1:0] x = rnd();
    logic [W-1:0] y = rnd();
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = x;
    b = y;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        acc.push_back(c);
        push_exp(x, y);
      end
      if (out_valid) begin
        e = sb.pop_front();
        checks++; if (diff !== e.d || borrow !== e.br) begin
          errors++; $display("FAIL b2b_diff got %h/%b exp %h/%b", diff, borrow, e.d, e.br);
        end
      end
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    checks++; if (acc.size() < 2 || acc[1] - acc[0] !== 14) begin
      errors++; $display("FAIL b2b_interval got %0d accepts exp spacing 14", acc.size());
    end
    wait_out(lat);
    checks++; if (!out_valid || sb.size() == 0) begin
      errors++; $display("FAIL b2b_drain got vld=%b pending=%0d exp vld=1 pending=1", out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++; if (diff !== e.d) begin errors++; $display("FAIL b2b_last got %h exp %h", diff, e.d); end
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL b2b_scoreboard got %0d left exp 0", sb.size()); end
  endtask

`ifdef SUB_1506_SEQ_ABORT_EN
  task automatic test_abort();
    int lat;
    int seen = 0;
    send('0, W'(1));
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    sb.delete();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_run got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_output got %0d pulses exp 0", seen); end
    send(W'(5), W'(3));
    wait_out(lat);
    abort = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0; out_ready = 1'b0;
    sb.delete();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_done got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; abort = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_idle_accept got rdy=%b exp 0", in_ready); end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef SUB_1506_SEQ_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
